// File: rtl/gba_mem_pkg.sv
// Shared memory-bus types: access size codes, bus owner and arbiter states.
package gba_mem_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  typedef enum logic {
    OWN_CPU,
    OWN_DMA
  } owner_t;

  typedef enum logic [1:0] {
    CPU_OWN,
    DMA_OWN,
    CPU_SLOT
  } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// CPU/DMA arbiter for the single memory port of mem_top.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// CPU_OWN  | CPU drives the bus, DMA stalled
// DMA_OWN  | DMA drives the bus, CPU stalled, burst counter running
// CPU_SLOT | forced CPU access after a full DMA burst, then hand back
//
// Ownership only moves when the current owner is neither writing nor
// waiting on the post-write pause, so a write and its pause stay with
// one owner. Read data follows the previous cycle's owner to match the
// one-cycle read latency of the memory.
module mem_bus_arbiter
  import gba_mem_pkg::*;
#(
  parameter int unsigned DMA_MAX_BURST = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_write,
  output logic [31:0] cpu_rdata,
  output logic        cpu_pause,
  input  logic        dma_req,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [1:0]  dma_size,
  input  logic        dma_write,
  output logic        dma_grant,
  output logic [31:0] dma_rdata,
  output logic        dma_pause,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  input  logic        mem_pause
);

  localparam bit               BURST_EN   = (DMA_MAX_BURST != 0);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(DMA_MAX_BURST - 1);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  owner_t           owner, owner_d1;
  logic             switch_ok;

  // State, burst counter and delayed owner for read-data routing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= CPU_OWN;
      burst_cnt <= '0;
      owner_d1  <= OWN_CPU;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
      owner_d1  <= owner;
    end
  end

  // Next-state and burst-count decision at transaction boundaries.
  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    case (state)
      CPU_OWN: begin
        if (dma_req && switch_ok) begin
          state_nxt     = DMA_OWN;
          burst_cnt_nxt = '0;
        end
      end
      DMA_OWN: begin
        if (switch_ok && !dma_req) begin
          state_nxt     = CPU_OWN;
          burst_cnt_nxt = '0;
        end else if (BURST_EN && switch_ok && (burst_cnt == BURST_LAST)) begin
          state_nxt = CPU_SLOT;
        end else if (BURST_EN && (burst_cnt != BURST_LAST)) begin
          burst_cnt_nxt = burst_cnt + CNT_W'(1);
        end
      end
      CPU_SLOT: begin
        // The slot cycle itself is the first evaluation, so the CPU always
        // gets at least one cycle; a slot write holds the slot until done.
        if (switch_ok) begin
          state_nxt     = dma_req ? DMA_OWN : CPU_OWN;
          burst_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt     = CPU_OWN;
        burst_cnt_nxt = '0;
      end
    endcase
  end

  // Bus mux, pause and read-data routing, all derived from the state.
  always_comb begin
    owner     = (state == DMA_OWN) ? OWN_DMA : OWN_CPU;
    dma_grant = (state == DMA_OWN);
    if (owner == OWN_DMA) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_size  = dma_size;
      mem_write = dma_write;
      dma_pause = mem_pause;
      cpu_pause = 1'b1;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_size  = cpu_size;
      mem_write = cpu_write;
      cpu_pause = mem_pause;
      dma_pause = 1'b1;
    end
    switch_ok = !mem_write && !mem_pause;
    cpu_rdata = (owner_d1 == OWN_CPU) ? mem_rdata : '0;
    dma_rdata = (owner_d1 == OWN_DMA) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter with a small mem_top stand-in (one-cycle read
// latency, pause the cycle after a write) and a cycle-level ownership model.
module tb_mem_bus_arbiter;
  import gba_mem_pkg::*;

  localparam int B = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [1:0]  cpu_size;
  logic        cpu_write, cpu_pause;
  logic        dma_req, dma_write, dma_grant, dma_pause;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic [1:0]  dma_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;
  logic        mem_write, mem_pause;

  always #5 clock = ~clock;

  mem_bus_arbiter #(.DMA_MAX_BURST(B), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_size(cpu_size),
    .cpu_write(cpu_write), .cpu_rdata(cpu_rdata), .cpu_pause(cpu_pause),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_size(dma_size), .dma_write(dma_write), .dma_grant(dma_grant),
    .dma_rdata(dma_rdata), .dma_pause(dma_pause),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_pause(mem_pause)
  );

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a5a_0f0f;
  endfunction

  // Memory stand-in: read data is a fixed function of last cycle's address.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_pause <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_pause <= mem_write;
      mem_rdata <= rd_fn(mem_addr);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Ownership model: who holds the bus, how long the DMA has held it, and
  // whether the CPU is in its forced slot.
  logic        m_dma, m_slot, m_pause, m_prev_dma, m_prev_valid;
  int          m_run;
  logic [31:0] m_prev_addr;

  task automatic model_reset();
    m_dma = 0; m_slot = 0; m_pause = 0; m_prev_dma = 0; m_prev_valid = 0;
    m_run = 0; m_prev_addr = '0;
  endtask

  task automatic model_compare();
    chk("grant", 32'(dma_grant), 32'(m_dma));
    chk("cpu_pause", 32'(cpu_pause), m_dma ? 32'd1 : 32'(m_pause));
    chk("dma_pause", 32'(dma_pause), m_dma ? 32'(m_pause) : 32'd1);
    chk("mem_addr", mem_addr, m_dma ? dma_addr : cpu_addr);
    chk("mem_wdata", mem_wdata, m_dma ? dma_wdata : cpu_wdata);
    chk("mem_size", 32'(mem_size), m_dma ? 32'(dma_size) : 32'(cpu_size));
    chk("mem_write", 32'(mem_write), m_dma ? 32'(dma_write) : 32'(cpu_write));
    if (m_prev_valid) begin
      chk("cpu_rdata", cpu_rdata, m_prev_dma ? 32'd0 : rd_fn(m_prev_addr));
      chk("dma_rdata", dma_rdata, m_prev_dma ? rd_fn(m_prev_addr) : 32'd0);
    end
  endtask

  task automatic model_step();
    logic ow, sw;
    ow = m_dma ? dma_write : cpu_write;
    sw = !ow && !m_pause;
    m_prev_addr  = m_dma ? dma_addr : cpu_addr;
    m_prev_dma   = m_dma;
    m_prev_valid = 1;
    m_pause      = ow;
    if (m_slot) begin
      if (sw) begin m_slot = 0; m_dma = dma_req; m_run = 1; end
    end else if (!m_dma) begin
      if (dma_req && sw) begin m_dma = 1; m_run = 1; end
    end else begin
      if (sw && !dma_req) m_dma = 0;
      else if (sw && B != 0 && m_run >= B) begin m_dma = 0; m_slot = 1; end
      else m_run++;
    end
  endtask

  task automatic idle_inputs();
    cpu_addr = 32'h0300_0000; cpu_wdata = '0; cpu_size = MEM_SIZE_WORD; cpu_write = 0;
    dma_req = 0; dma_addr = 32'h0200_0040; dma_wdata = '0; dma_size = MEM_SIZE_WORD;
    dma_write = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    @(posedge clock); @(posedge clock); #1;
    reset = 0;
    model_reset();
  endtask

  typedef struct {
    logic        dma_req;
    logic        cpu_write;
    logic [31:0] cpu_addr;
    logic        e_grant;
    logic        e_cpu_pause;
    logic        e_dma_pause;
    logic        e_write;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] prev_addr, prev_dma_addr;
    logic        prev_grant;
    logic [10:0] pat;
    int          unpaused;

    vecs[0]  = '{0, 0, 32'h0300_0000, 0, 0, 1, 0};
    vecs[1]  = '{1, 0, 32'h0300_0000, 0, 0, 1, 0};
    vecs[2]  = '{1, 0, 32'h0300_0000, 1, 1, 0, 0};
    vecs[3]  = '{0, 0, 32'h0300_0000, 1, 1, 0, 0};
    vecs[4]  = '{0, 0, 32'h0300_0000, 0, 0, 1, 0};
    vecs[5]  = '{1, 1, 32'h0600_0000, 0, 0, 1, 1};
    vecs[6]  = '{1, 0, 32'h0600_0000, 0, 1, 1, 0};
    vecs[7]  = '{1, 0, 32'h0600_0000, 0, 0, 1, 0};
    vecs[8]  = '{1, 0, 32'h0300_0000, 1, 1, 0, 0};
    vecs[9]  = '{0, 0, 32'h0300_0000, 1, 1, 0, 0};
    vecs[10] = '{0, 0, 32'h0300_0000, 0, 0, 1, 0};

    // Reset values while reset is held.
    idle_inputs();
    #2;
    chk("rst_grant", 32'(dma_grant), 32'd0);
    chk("rst_dma_pause", 32'(dma_pause), 32'd1);
    chk("rst_cpu_pause", 32'(cpu_pause), 32'(mem_pause));
    chk("rst_dma_rdata", dma_rdata, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, mem_rdata);
    chk("rst_mem_addr", mem_addr, 32'h0300_0000);
    do_reset();

    // Directed table: idle read, DMA grant and release, write blocking a switch.
    prev_addr = '0; prev_grant = 0;
    for (int i = 0; i < 11; i++) begin
      dma_req = vecs[i].dma_req; cpu_write = vecs[i].cpu_write; cpu_addr = vecs[i].cpu_addr;
      @(negedge clock);
      chk($sformatf("vec%0d_grant", i), 32'(dma_grant), 32'(vecs[i].e_grant));
      chk($sformatf("vec%0d_cpu_pause", i), 32'(cpu_pause), 32'(vecs[i].e_cpu_pause));
      chk($sformatf("vec%0d_dma_pause", i), 32'(dma_pause), 32'(vecs[i].e_dma_pause));
      chk($sformatf("vec%0d_mem_write", i), 32'(mem_write), 32'(vecs[i].e_write));
      chk($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].e_grant ? dma_addr : vecs[i].cpu_addr);
      if (i > 0)
        chk($sformatf("vec%0d_cpu_rdata", i), cpu_rdata, prev_grant ? 32'd0 : rd_fn(prev_addr));
      prev_addr  = vecs[i].e_grant ? dma_addr : vecs[i].cpu_addr;
      prev_grant = vecs[i].e_grant;
      @(posedge clock); #1;
    end

    // Burst limit: grant pattern 0 then 1,1,1,1,0,1,1,1,1,0 with reads.
    idle_inputs();
    dma_req = 1;
    pat = 11'b01111011110;
    unpaused = 0;
    prev_dma_addr = '0;
    for (int i = 0; i < 11; i++) begin
      dma_addr = 32'h0200_0000 + 32'(i * 4);
      @(negedge clock);
      chk($sformatf("burst%0d_grant", i), 32'(dma_grant), 32'(pat[10 - i]));
      if (i > 0 && !cpu_pause) unpaused++;
      if (i > 1 && !pat[10 - i]) begin
        chk($sformatf("burst%0d_dma_rdata", i), dma_rdata, rd_fn(prev_dma_addr));
        chk($sformatf("burst%0d_cpu_rdata", i), cpu_rdata, 32'd0);
      end
      prev_dma_addr = dma_addr;
      @(posedge clock); #1;
    end
    chk("burst_cpu_slots", 32'(unpaused), 32'd2);

    // Reset in the last DMA cycle of a burst (counter at B-1).
    @(posedge clock); @(posedge clock); @(posedge clock); #1;
    chk("midburst_grant", 32'(dma_grant), 32'd1);
    #2 reset = 1;
    #1 chk("async_grant_drop", 32'(dma_grant), 32'd0);
    chk("async_dma_pause", 32'(dma_pause), 32'd1);
    @(posedge clock); #1;
    reset = 0;
    pat = 11'b01111000000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk($sformatf("postrst%0d_grant", i), 32'(dma_grant), 32'(pat[10 - i]));
      @(posedge clock); #1;
    end

    // Randomized traffic against the ownership model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      dma_req   = ($urandom_range(0, 3) != 0);
      cpu_write = ($urandom_range(0, 4) == 0);
      dma_write = ($urandom_range(0, 4) == 0);
      cpu_addr  = $urandom; dma_addr = $urandom;
      cpu_wdata = $urandom; dma_wdata = $urandom;
      cpu_size  = 2'($urandom_range(0, 2)); dma_size = 2'($urandom_range(0, 2));
      @(negedge clock);
      model_compare();
      model_step();
      @(posedge clock); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
